seg_scan_controller: RTL
========================

Name: seg_scan_controller

Overview:
- Time-multiplexes a 16-bit value onto the 4-digit common-anode seven-segment display.
- Drives the active-low anodes. Presents one nibble at a time on disp_val to the hex segment decoder, which produces the cathode pattern.
- Inserts a blanking gap between digits to prevent ghosting.
- Updates the displayed value only at frame boundaries so digits never tear. Optionally suppresses leading zeros.

Parameters:
ON_CYCLES, 100000, clock cycles each digit is driven (1 kHz digit rate at 100 MHz); must be >=1
BLANK_CYCLES, 1000, clock cycles all anodes are off between digits; must be >=1
CNT_W, 17, width of the internal interval counter; must hold max(ON_CYCLES, BLANK_CYCLES)-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = scanning; 0 = display dark
value_in  in  16  value to display; nibble 0 is the rightmost digit
load  in  1  one-cycle strobe; captures value_in into the shadow register
lz_en  in  1  1 = suppress leading zero digits
disp_val  out  4  nibble for the segment decoder (registered)
anode  out  4  active-low digit enables; anode[i] drives digit i (registered)
frame_done  out  1  one-cycle pulse at the end of digit 3's ON period

Behaviour:
- Reset (async, rst_n=0), effective immediately:
  - anode=4'b1111, disp_val=4'h0, frame_done=0.
  - State IDLE, digit index idx=0, counter=0.
  - Shadow and displayed registers = 16'h0000, pending flag=0.
- Reset mid-scan has the same effect. After release, scanning resumes from IDLE.
- Value capture:
  - load=1 on a rising edge: shadow<=value_in, pending<=1.
  - Multiple loads within one frame: the last one wins.
  - On entry to ON for idx=0 with pending=1: displayed<=shadow, pending<=0, in the same edge.
  - The new nibble 0 therefore appears on the first ON cycle of the new frame.
- States:
  - IDLE: anode=1111, idx=0, counter=0. If enable=1, the next edge enters BLANK with disp_val=nibble 0.
  - BLANK: anode=1111 for BLANK_CYCLES cycles. disp_val is preset to the nibble of idx, so the decoder settles before the anode turns on. Then enter ON.
  - ON: anode[idx]=0 and the other anodes=1, held for ON_CYCLES cycles.
    - If digit idx is suppressed, anode stays 1111 for the slot; timing is unchanged.
    - At the end of the slot: idx<=idx+1 (wraps 3->0), enter BLANK.
    - frame_done=1 for exactly the cycle in which idx wraps from 3 to 0.
- enable=0 in any state: the next edge goes to IDLE (anode=1111, idx=0), abandoning the frame. No frame_done is emitted. pending is kept.
- Leading-zero suppression (lz_en=1):
  - Digit k (k=3..1) is blank if displayed nibbles k..3 are all zero.
  - Digit 0 is always shown, so 0x0000 shows "0".
  - lz_en is sampled at entry to each ON slot.
- disp_val only changes on BLANK entry or on IDLE->BLANK. It never changes while an anode is low.
- Counter: counts 0..interval-1 and resets to 0 on every state change. No sub-cycle glitches on anode, since all outputs are registered.
- Simultaneous load and frame-boundary update on the same edge: the boundary copies the old shadow. The new load sets pending=1 and is shown in the next frame.

Test Plan:
- ON_CYCLES=4, BLANK_CYCLES=2; reset, enable=1, load 16'h1234 -> from the first frame boundary, anode sequence 1110/1101/1011/0111 with disp_val 4/3/2/1. Each digit low for 4 cycles, separated by 2 cycles of 1111. frame_done pulses once every 24 cycles.
- Load 16'hABCD while digit 2 is ON -> digits 2 and 3 of the current frame still show the old value. The next frame shows D,C,B,A. No mixed frame.
- lz_en=1, load 16'h0050 -> digits 3 and 2 keep anode=1111 during their slots. Digits 1 and 0 show 5 and 0. With load 16'h0000, only digit 0 lights, showing 0.
- Drop enable during digit 1's ON slot -> the next cycle shows anode=1111 and idx=0. No frame_done. Re-enable -> BLANK, then digit 0 first.
- Assert rst_n=0 asynchronously mid-ON -> anode=1111 and disp_val=0 immediately, with no clock edge. The display shows 0000 after release.
- Two loads (16'h1111, then 16'h2222) in one frame, with a third load coinciding with the boundary edge -> the next frame shows 2222. The third value appears one frame later.

Source files
------------

// File: rtl/seg_scan_controller_if.sv
// Control and display signals between the seven-segment scan controller and its host.
// Clock and reset are plain ports on the controller, not part of this bundle.
interface seg_scan_controller_if;
    logic        enable;
    logic [15:0] value_in;
    logic        load;
    logic        lz_en;
    logic [3:0]  disp_val;
    logic [3:0]  anode;
    logic        frame_done;

    modport master (
        output enable, value_in, load, lz_en,
        input  disp_val, anode, frame_done
    );

    modport slave (
        input  enable, value_in, load, lz_en,
        output disp_val, anode, frame_done
    );
endinterface

// File: rtl/seg_scan_controller.sv
// Four-digit common-anode seven-segment scanner with inter-digit blanking,
// frame-synchronous value update and optional leading-zero suppression.
//
// state | meaning
// IDLE  | display dark, idx=0, waiting for enable
// BLANK | all anodes off, disp_val preset to nibble of idx
// ON    | anode[idx] low (unless suppressed) for ON_CYCLES
module seg_scan_controller #(
    parameter int unsigned ON_CYCLES    = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned CNT_W        = 17
) (
    input  logic                   clk,
    input  logic                   rst_n,
    seg_scan_controller_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_ON    = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       shadow_q, shadow_d;
    logic [15:0]       shown_q, shown_d;
    logic              pending_q, pending_d;
    logic [3:0]        disp_val_q, disp_val_d;
    logic [3:0]        anode_q, anode_d;
    logic              frame_done_q, frame_done_d;

    logic [1:0]        next_idx;
    logic [15:0]       frame_src;

    // Digit i is dark when it and every digit above it are zero; digit 0 always shows.
    function automatic logic digit_blank(input logic [15:0] v, input logic [1:0] i);
        case (i)
            2'd3:    digit_blank = (v[15:12] == 4'h0);
            2'd2:    digit_blank = (v[15:8]  == 8'h00);
            2'd1:    digit_blank = (v[15:4]  == 12'h000);
            default: digit_blank = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        shadow_d     = shadow_q;
        shown_d      = shown_q;
        pending_d    = pending_q;
        disp_val_d   = disp_val_q;
        anode_d      = anode_q;
        frame_done_d = 1'b0;

        next_idx  = idx_q + 2'd1;
        // Value the next frame will show, so digit 0 can be preset before its slot.
        frame_src = pending_q ? shadow_q : shown_q;

        if (!bus.enable) begin
            state_d = ST_IDLE;
            idx_d   = 2'd0;
            cnt_d   = '0;
            anode_d = 4'b1111;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d    = ST_BLANK;
                    idx_d      = 2'd0;
                    cnt_d      = '0;
                    anode_d    = 4'b1111;
                    disp_val_d = frame_src[3:0];
                end
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_ON;
                        cnt_d   = '0;
                        if (idx_q == 2'd0 && pending_q) begin
                            shown_d    = shadow_q;
                            pending_d  = 1'b0;
                            disp_val_d = shadow_q[3:0];
                        end
                        if (bus.lz_en && digit_blank(shown_q, idx_q))
                            anode_d = 4'b1111;
                        else
                            anode_d = ~(4'b0001 << idx_q);
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_ON: begin
                    if (cnt_q == ON_LAST) begin
                        state_d      = ST_BLANK;
                        cnt_d        = '0;
                        idx_d        = next_idx;
                        anode_d      = 4'b1111;
                        frame_done_d = (idx_q == 2'd3);
                        if (next_idx == 2'd0)
                            disp_val_d = frame_src[3:0];
                        else
                            disp_val_d = shown_q[{next_idx, 2'b00} +: 4];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = 2'd0;
                    cnt_d   = '0;
                    anode_d = 4'b1111;
                end
            endcase
        end

        // A load on the frame-boundary edge lands after the copy, so it waits a frame.
        if (bus.load) begin
            shadow_d  = bus.value_in;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= 2'd0;
            cnt_q        <= '0;
            shadow_q     <= 16'h0000;
            shown_q      <= 16'h0000;
            pending_q    <= 1'b0;
            disp_val_q   <= 4'h0;
            anode_q      <= 4'b1111;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            shown_q      <= shown_d;
            pending_q    <= pending_d;
            disp_val_q   <= disp_val_d;
            anode_q      <= anode_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bus.disp_val   = disp_val_q;
    assign bus.anode      = anode_q;
    assign bus.frame_done = frame_done_q;

endmodule
